// File: rtl/gtx_frame_pkg.sv
// gtx_frame_pkg: constants, state encoding and the header-length rule shared
// by the 16-bit GTX frame sender and receiver.
//   K_CHAR_DEF    : comma word carried in every K slot
//   HEAD_WORD_DEF : frame-head marker, sent twice back to back
//   LEN_W_DEF     : width of the 64-bit payload word count
//   rx_state_t    : receiver FSM states
//   len_from_hdr  : payload word count encoded in the low header lane
package gtx_frame_pkg;

    localparam logic [15:0] K_CHAR_DEF    = 16'h50BC;
    localparam logic [15:0] HEAD_WORD_DEF = 16'hA0AA;
    localparam int          LEN_W_DEF     = 15;

    typedef enum logic [1:0] {
        UNLOCK  = 2'd0,
        HUNT    = 2'd1,
        HDR     = 2'd2,
        PAYLOAD = 2'd3
    } rx_state_t;

    // The sender encodes the byte length; whole 64-bit words are hdr[15:2]+1,
    // with one extra word when both low bits are set. Wraps at LEN_W_DEF bits.
    function automatic logic [LEN_W_DEF-1:0] len_from_hdr(input logic [15:0] hdr);
        logic [LEN_W_DEF-1:0] base;
        logic [LEN_W_DEF-1:0] extra;
        base  = {1'b0, hdr[15:2]};
        extra = {{(LEN_W_DEF-1){1'b0}}, hdr[1] & hdr[0]};
        return base + LEN_W_DEF'(1) + extra;
    endfunction

endpackage

// File: rtl/gtx_word_packer.sv
// gtx_word_packer: shifts 16-bit data slots into 64-bit words, first slot in
// the most significant lane.
//   DataRecvCLK : clock
//   RST         : synchronous active-high reset
//   flush       : drop any partial word (highest priority)
//   preset      : load the two head lanes and continue from lane 2
//   push        : append din as the next lane
//   din         : data slot
//   word_done   : push that completes lane 3 in this cycle (combinational)
//   word_o      : last completed 64-bit word, held between strobes
//   vld_o       : one-cycle strobe, one cycle after the completing slot
module gtx_word_packer
    import gtx_frame_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] HEAD_WORD = HEAD_WORD_DEF
) (
    input  logic                DataRecvCLK,
    input  logic                RST,
    input  logic                flush,
    input  logic                preset,
    input  logic                push,
    input  logic [DATA_W-1:0]   din,
    output logic                word_done,
    output logic [4*DATA_W-1:0] word_o,
    output logic                vld_o
);

    logic [1:0]          lane_cnt;
    logic [3*DATA_W-1:0] lanes_p0;

    assign word_done = push & ~flush & ~preset & (lane_cnt == 2'd3);

    // Stage 0: lane shifter; stage 1: completed word and its strobe.
    always_ff @(posedge DataRecvCLK) begin
        if (RST) begin
            lane_cnt <= 2'd0;
            word_o   <= '0;
            vld_o    <= 1'b0;
        end else begin
            vld_o <= 1'b0;
            if (flush) begin
                lane_cnt <= 2'd0;
            end else if (preset) begin
                lanes_p0 <= {{DATA_W{1'b0}}, DATA_W'(HEAD_WORD), DATA_W'(HEAD_WORD)};
                lane_cnt <= 2'd2;
            end else if (push) begin
                lanes_p0 <= {lanes_p0[2*DATA_W-1:0], din};
                lane_cnt <= lane_cnt + 2'd1;
                if (lane_cnt == 2'd3) begin
                    word_o <= {lanes_p0, din};
                    vld_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gtx_frame_rx.sv
// gtx_frame_rx: receive side of the 16-bit GTX frame link. Locks on the
// periodic K character, hunts for the doubled head word, then repacks the
// header and payload into 64-bit words in original PCIe lane order.
// Optional build macro: ALIGN_CHECK_EN - enforce exactly one K every
// K_PERIOD cycles once locked; a misplaced or missing K acts as a bad K.
//   DataRecvCLK  : recovered GTX user clock
//   RST          : synchronous active-high reset
//   DataRecv     : received 16-bit word
//   DataRecvisK  : DataRecv is a K character
//   Data_PCIE_o  : reassembled 64-bit word
//   Valid_PCIE_o : one-cycle strobe per word
//   Frame_Start  : with the header word
//   Frame_End    : with the last payload word
//   Length_o     : payload word count, held until the next header
//   Locked       : K alignment achieved
//   Frame_Err    : one-cycle pulse on an aborted frame
module gtx_frame_rx
    import gtx_frame_pkg::*;
#(
    parameter logic [15:0] K_CHAR    = K_CHAR_DEF,
    parameter logic [15:0] HEAD_WORD = HEAD_WORD_DEF,
    parameter int          K_PERIOD  = 16,
    parameter int          LEN_W     = LEN_W_DEF
) (
    input  logic             DataRecvCLK,
    input  logic             RST,
    input  logic [15:0]      DataRecv,
    input  logic             DataRecvisK,
    output logic [63:0]      Data_PCIE_o,
    output logic             Valid_PCIE_o,
    output logic             Frame_Start,
    output logic             Frame_End,
    output logic [LEN_W-1:0] Length_o,
    output logic             Locked,
    output logic             Frame_Err
);

    rx_state_t        state;
    logic             head_seen;
    logic [LEN_W-1:0] wcnt;
    logic [LEN_W-1:0] wcnt_nxt;

    logic k_slot;
    logic bad_k;
    logic data_slot;
    logic align_err;
    logic lock_err;
    logic in_frame;
    logic pk_preset;
    logic pk_push;
    logic word_done;

    assign k_slot    = DataRecvisK & (DataRecv == K_CHAR);
    assign bad_k     = DataRecvisK & (DataRecv != K_CHAR);
    assign data_slot = ~DataRecvisK;

`ifdef ALIGN_CHECK_EN
    localparam int KCNT_W = (K_PERIOD > 1) ? $clog2(K_PERIOD) : 1;

    logic [KCNT_W-1:0] kcnt;

    // Cycles since the last K; the next K must land exactly at K_PERIOD-1.
    always_ff @(posedge DataRecvCLK) begin
        if (RST) begin
            kcnt <= '0;
        end else if (k_slot) begin
            kcnt <= '0;
        end else begin
            kcnt <= kcnt + KCNT_W'(1);
        end
    end

    assign align_err = (state != UNLOCK) &
                       ((k_slot  & (kcnt != KCNT_W'(K_PERIOD - 1))) |
                        (~k_slot & (kcnt == KCNT_W'(K_PERIOD - 1))));
`else
    // Degenerate periods leave no data slots; nothing to build for them.
    if (K_PERIOD < 2) begin : g_short_period
    end
    assign align_err = 1'b0;
`endif

    assign lock_err  = bad_k | align_err;
    assign in_frame  = (state == HDR) | (state == PAYLOAD);
    assign pk_preset = (state == HUNT) & data_slot & (DataRecv == HEAD_WORD)
                       & head_seen & ~lock_err;
    assign pk_push   = in_frame & data_slot & ~lock_err;
    assign wcnt_nxt  = wcnt + LEN_W'(1);

    gtx_word_packer #(
        .DATA_W    (16),
        .HEAD_WORD (HEAD_WORD)
    ) u_packer (
        .DataRecvCLK (DataRecvCLK),
        .RST         (RST),
        .flush       (lock_err),
        .preset      (pk_preset),
        .push        (pk_push),
        .din         (DataRecv),
        .word_done   (word_done),
        .word_o      (Data_PCIE_o),
        .vld_o       (Valid_PCIE_o)
    );

    // Frame control; flags register alongside the packer's word strobe.
    always_ff @(posedge DataRecvCLK) begin
        if (RST) begin
            state       <= UNLOCK;
            Locked      <= 1'b0;
            head_seen   <= 1'b0;
            wcnt        <= '0;
            Length_o    <= '0;
            Frame_Start <= 1'b0;
            Frame_End   <= 1'b0;
            Frame_Err   <= 1'b0;
        end else begin
            Frame_Start <= 1'b0;
            Frame_End   <= 1'b0;
            Frame_Err   <= 1'b0;
            if (state == UNLOCK) begin
                if (k_slot) begin
                    state     <= HUNT;
                    Locked    <= 1'b1;
                    head_seen <= 1'b0;
                end
            end else if (lock_err) begin
                // Lock loss aborts any frame in flight; the packer drops its partial word.
                state     <= UNLOCK;
                Locked    <= 1'b0;
                head_seen <= 1'b0;
                Frame_Err <= in_frame;
            end else begin
                case (state)
                    HUNT: begin
                        // K slots leave the match untouched, so a K may split the two heads.
                        if (data_slot) begin
                            if (DataRecv == HEAD_WORD) begin
                                if (head_seen) begin
                                    state     <= HDR;
                                    head_seen <= 1'b0;
                                end else begin
                                    head_seen <= 1'b1;
                                end
                            end else begin
                                head_seen <= 1'b0;
                            end
                        end
                    end
                    HDR: begin
                        if (word_done) begin
                            Frame_Start <= 1'b1;
                            Length_o    <= LEN_W'(len_from_hdr(DataRecv));
                            wcnt        <= '0;
                            state       <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (word_done) begin
                            wcnt <= wcnt_nxt;
                            if (wcnt_nxt == Length_o) begin
                                Frame_End <= 1'b1;
                                state     <= HUNT;
                            end
                        end
                    end
                    default: state <= UNLOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtx_frame_rx.sv
module tb_gtx_frame_rx;

    localparam logic [15:0] KC   = 16'h50BC;
    localparam logic [15:0] HEAD = 16'hA0AA;

    logic        DataRecvCLK;
    logic        RST;
    logic [15:0] DataRecv;
    logic        DataRecvisK;
    logic [63:0] Data_PCIE_o;
    logic        Valid_PCIE_o;
    logic        Frame_Start;
    logic        Frame_End;
    logic [14:0] Length_o;
    logic        Locked;
    logic        Frame_Err;

    gtx_frame_rx dut (
        .DataRecvCLK  (DataRecvCLK),
        .RST          (RST),
        .DataRecv     (DataRecv),
        .DataRecvisK  (DataRecvisK),
        .Data_PCIE_o  (Data_PCIE_o),
        .Valid_PCIE_o (Valid_PCIE_o),
        .Frame_Start  (Frame_Start),
        .Frame_End    (Frame_End),
        .Length_o     (Length_o),
        .Locked       (Locked),
        .Frame_Err    (Frame_Err)
    );

    initial DataRecvCLK = 1'b0;
    always #5 DataRecvCLK = ~DataRecvCLK;

    typedef struct packed {
        logic        rst;
        logic        isk;
        logic [15:0] d;
    } slot_t;

    typedef struct packed {
        logic        vld;
        logic        start;
        logic        fend;
        logic        err;
        logic        locked;
        logic [63:0] data;
        logic [14:0] len;
    } exp_t;

    slot_t       stim[$];
    exp_t        expq[$];
    logic [63:0] dut_words[$];
    logic [14:0] dut_lens[$];
    int          phase;
    int          errors;
    int          checks;
    int          cyc;
    int          n_start;
    int          n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    // Stream builders: a K is inserted whenever 15 data slots have followed the last K.
    task automatic add_k();
        stim.push_back('{1'b0, 1'b1, KC});
        phase = 1;
    endtask

    task automatic add_d(input logic [15:0] v);
        if (phase >= 16) add_k();
        stim.push_back('{1'b0, 1'b0, v});
        phase++;
    endtask

    task automatic add_bad_k();
        stim.push_back('{1'b0, 1'b1, 16'h50BD});
        phase++;
    endtask

    task automatic add_rst();
        stim.push_back('{1'b1, 1'b0, 16'h0000});
        phase = 0;
    endtask

    task automatic add_hdr(input logic [15:0] h);
        add_d(HEAD);
        add_d(HEAD);
        add_d(16'h0000);
        add_d(h);
    endtask

    task automatic add_filler(input int n);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = 16'($urandom);
            if (v == HEAD) v = 16'h1111;
            add_d(v);
        end
    endtask

    task automatic add_payload(input int n);
        for (int i = 0; i < n; i++) add_d(16'($urandom));
    endtask

    // Reference: frame-level parse of the slot stream. Per slot it records the
    // outputs expected right after that slot's clock edge.
    task automatic build_model();
        logic        locked, inframe, prev, hdr_done;
        logic [15:0] fw[$];
        logic [63:0] cur_data;
        logic [14:0] cur_len;
        int          pc;
        exp_t        e;
        locked = 0; inframe = 0; prev = 0; hdr_done = 0;
        cur_data = '0; cur_len = '0; pc = 0;
        foreach (stim[i]) begin
            e = '0;
            if (stim[i].rst) begin
                locked = 0; inframe = 0; prev = 0; fw.delete();
                cur_data = '0; cur_len = '0;
            end else if (stim[i].isk && stim[i].d == KC) begin
                if (!locked) begin
                    locked = 1;
                    prev = 0;
                end
            end else if (stim[i].isk) begin
                if (locked) begin
                    e.err = inframe;
                    locked = 0; inframe = 0; prev = 0; fw.delete();
                end
            end else if (locked) begin
                if (!inframe) begin
                    if (stim[i].d == HEAD) begin
                        if (prev) begin
                            inframe = 1; hdr_done = 0; prev = 0;
                            fw.delete();
                            fw.push_back(HEAD);
                            fw.push_back(HEAD);
                        end else begin
                            prev = 1;
                        end
                    end else begin
                        prev = 0;
                    end
                end else begin
                    fw.push_back(stim[i].d);
                    if (fw.size() == 4) begin
                        cur_data = {fw[0], fw[1], fw[2], fw[3]};
                        e.vld = 1;
                        if (!hdr_done) begin
                            hdr_done = 1;
                            e.start = 1;
                            cur_len = 15'((int'(fw[3]) >> 2) + 1 + ((fw[3][1:0] == 2'b11) ? 1 : 0));
                            pc = 0;
                        end else begin
                            pc++;
                            if (pc == int'(cur_len)) begin
                                e.fend = 1;
                                inframe = 0;
                            end
                        end
                        fw.delete();
                    end
                end
            end
            e.locked = locked;
            e.data   = cur_data;
            e.len    = cur_len;
            expq.push_back(e);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; n_start = 0; n_err = 0; phase = 0;
        RST = 1'b1; DataRecv = 16'h0000; DataRecvisK = 1'b0;

        // Reset, lock and basic frame
        add_rst();
        add_rst();
        add_k();
        add_filler(4);
        add_hdr(16'h0004);
        for (int i = 1; i <= 8; i++) add_d(16'(i));
        add_filler(3);
        // K inside a payload word
        add_hdr(16'h0004);
        add_d(16'h0001);
        add_d(16'h0002);
        add_k();
        for (int i = 3; i <= 8; i++) add_d(16'(i));
        // Length rounding: 7 -> 3 words
        add_filler(2);
        add_hdr(16'h0007);
        add_payload(12);
        // Filler and a false head
        for (int i = 0; i < 16; i++) add_d(16'(i));
        add_d(HEAD);
        add_d(16'h1234);
        add_filler(6);
        // Bad K mid-payload, then relock and a one-word frame
        add_hdr(16'h0008);
        add_payload(5);
        add_bad_k();
        add_filler(5);
        add_k();
        add_hdr(16'h0001);
        add_payload(4);
        // RST mid-payload, then relock
        add_filler(2);
        add_hdr(16'h000B);
        add_payload(6);
        add_rst();
        add_filler(2);
        add_k();
        add_hdr(16'h0000);
        add_payload(4);
        add_filler(3);

        build_model();

        foreach (stim[i]) begin
            RST         = stim[i].rst;
            DataRecvisK = stim[i].isk;
            DataRecv    = stim[i].d;
            @(posedge DataRecvCLK);
            #1;
            cyc = i;
            chk("valid",  64'(Valid_PCIE_o), 64'(expq[i].vld));
            chk("start",  64'(Frame_Start),  64'(expq[i].start));
            chk("end",    64'(Frame_End),    64'(expq[i].fend));
            chk("err",    64'(Frame_Err),    64'(expq[i].err));
            chk("locked", 64'(Locked),       64'(expq[i].locked));
            chk("data",   Data_PCIE_o,       expq[i].data);
            chk("length", 64'(Length_o),     64'(expq[i].len));
            if (Valid_PCIE_o === 1'b1) dut_words.push_back(Data_PCIE_o);
            if (Frame_Start === 1'b1) begin
                n_start++;
                dut_lens.push_back(Length_o);
            end
            if (Frame_Err === 1'b1) n_err++;
        end

        cyc = -1;
        chk("words_seen", 64'(dut_words.size() >= 6), 64'(1));
        chk("f1_hdr",   dut_words[0], 64'hA0AA_A0AA_0000_0004);
        chk("f1_w1",    dut_words[1], 64'h0001_0002_0003_0004);
        chk("f1_w2",    dut_words[2], 64'h0005_0006_0007_0008);
        chk("f2_hdr",   dut_words[3], 64'hA0AA_A0AA_0000_0004);
        chk("f2_w1",    dut_words[4], 64'h0001_0002_0003_0004);
        chk("f2_w2",    dut_words[5], 64'h0005_0006_0007_0008);
        chk("lens_seen", 64'(dut_lens.size() >= 3), 64'(1));
        chk("len_f1",   64'(dut_lens[0]), 64'd2);
        chk("len_f3",   64'(dut_lens[2]), 64'd3);
        chk("n_start",  64'(n_start), 64'd7);
        chk("n_err",    64'(n_err),   64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
